// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game engine: direction and state
// encodings plus the coordinate-step arithmetic.
package snake_pkg;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_e;

    typedef enum logic [1:0] {
        PLAY,
        PLACE,
        DEAD,
        WIN
    } state_e;

    // Widest axis the step helper supports; callers use only GRID_BITS of it.
    localparam int AXIS_W = 16;

    typedef struct packed {
        logic              off;
        logic [AXIS_W-1:0] x;
        logic [AXIS_W-1:0] y;
    } step_t;

    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return (a == UP    && b == DOWN) || (a == DOWN  && b == UP) ||
               (a == LEFT  && b == RIGHT) || (a == RIGHT && b == LEFT);
    endfunction

    // Move one cell in direction d on a 2^gbits grid. With wrap set the
    // result folds modulo the grid size; otherwise off flags an edge exit.
    function automatic step_t step(input logic [AXIS_W-1:0] x,
                                   input logic [AXIS_W-1:0] y,
                                   input dir_e              d,
                                   input int                gbits,
                                   input logic              wrap);
        int    nx;
        int    ny;
        int    g;
        step_t r;
        g  = 1 << gbits;
        nx = int'(x);
        ny = int'(y);
        case (d)
            UP:      ny = ny - 1;
            DOWN:    ny = ny + 1;
            LEFT:    nx = nx - 1;
            default: nx = nx + 1;
        endcase
        r.off = !wrap && (nx < 0 || nx >= g || ny < 0 || ny >= g);
        r.x   = AXIS_W'(nx & (g - 1));
        r.y   = AXIS_W'(ny & (g - 1));
        return r;
    endfunction

endpackage

// File: rtl/snake_occupancy.sv
// Combinational hit test: does coord_i match any of the first upto_i
// segments of the flattened body?
module snake_occupancy
#(
    parameter int CW      = 8,
    parameter int MAX_LEN = 16,
    parameter int LW      = 5
) (
    input  logic [CW-1:0]         coord_i,
    input  logic [MAX_LEN*CW-1:0] segs_i,
    input  logic [LW-1:0]         upto_i,
    output logic                  hit_o
);

    // Compare against every segment below the length mask.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < upto_i && segs_i[i*CW +: CW] == coord_i) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_core.sv
// Snake game engine: body, apple, score and direction state, advanced one
// grid step per tick, with collision-checked apple placement.
module snake_core
    import snake_pkg::*;
#(
    parameter int                     GRID_BITS = 4,
    parameter int                     MAX_LEN   = 16,
    parameter int                     INIT_LEN  = 3,
    parameter bit                     WRAP      = 1'b0,
    parameter logic [2*GRID_BITS-1:0] BARRIER   = 8'h44
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tick,
    input  logic                               up,
    input  logic                               down,
    input  logic                               left,
    input  logic                               right,
    input  logic [2*GRID_BITS-1:0]             rnd,
    output logic [MAX_LEN*2*GRID_BITS-1:0]     snake,
    output logic [$clog2(MAX_LEN+1)-1:0]       length,
    output logic [2*GRID_BITS-1:0]             apple,
    output logic [2*GRID_BITS-1:0]             barrier,
    output logic [$clog2(MAX_LEN+1)-1:0]       score,
    output logic                               score_flag,
    output logic                               dead_flag,
    output logic                               win_flag
);

    localparam int CW = 2 * GRID_BITS;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int C  = 1 << (GRID_BITS - 1);
    localparam int G  = 1 << GRID_BITS;

    typedef logic [CW-1:0] coord_t;

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d;
    dir_e            pend_q, pend_d;
    logic            hold_q, hold_d;
    coord_t          body_q [MAX_LEN];
    coord_t          body_d [MAX_LEN];
    logic [LW-1:0]   length_q, length_d;
    logic [LW-1:0]   score_q, score_d;
    coord_t          apple_q, apple_d;
    logic            score_flag_q, score_flag_d;
    logic            dead_q, dead_d;
    logic            win_q, win_d;

    logic [MAX_LEN*CW-1:0] body_flat;
    dir_e            req;
    logic            btn_any;
    step_t           st;
    coord_t          nh;
    logic            eat;
    logic            dies;
    logic            nh_hit;
    logic            rnd_hit;
    logic [LW-1:0]   upto_nh;
    logic [LW-1:0]   new_len;
    logic            unused_step_bits;

    // Next head follows the latched request, which becomes the committed direction on the step.
    assign st = step(AXIS_W'(body_q[0][CW-1:GRID_BITS]), AXIS_W'(body_q[0][GRID_BITS-1:0]),
                     pend_q, GRID_BITS, WRAP);
    assign nh = {st.x[GRID_BITS-1:0], st.y[GRID_BITS-1:0]};
    assign unused_step_bits = ^{st.x[AXIS_W-1:GRID_BITS], st.y[AXIS_W-1:GRID_BITS]};

    assign eat     = (nh == apple_q);
    // The tail vacates its cell unless the snake grows, so it only blocks when eating.
    assign upto_nh = eat ? length_q : length_q - LW'(1);
    assign dies    = st.off || (nh == BARRIER) || nh_hit;

    snake_occupancy #(.CW(CW), .MAX_LEN(MAX_LEN), .LW(LW)) u_occ_head (
        .coord_i (nh),
        .segs_i  (body_flat),
        .upto_i  (upto_nh),
        .hit_o   (nh_hit)
    );

    snake_occupancy #(.CW(CW), .MAX_LEN(MAX_LEN), .LW(LW)) u_occ_rnd (
        .coord_i (rnd),
        .segs_i  (body_flat),
        .upto_i  (length_q),
        .hit_o   (rnd_hit)
    );

    // Highest-priority button request: up > down > left > right.
    always_comb begin
        btn_any = up | down | left | right;
        if (up)        req = UP;
        else if (down) req = DOWN;
        else if (left) req = LEFT;
        else           req = RIGHT;
    end

    // Next-state logic for the game FSM and all datapath registers.
    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        hold_d       = hold_q;
        body_d       = body_q;
        length_d     = length_q;
        score_d      = score_q;
        apple_d      = apple_q;
        score_flag_d = 1'b0;
        dead_d       = dead_q;
        win_d        = win_q;
        new_len      = length_q;

        case (state_q)
            PLAY: begin
                if (tick || hold_q) begin
                    hold_d = 1'b0;
                    dir_d  = pend_q;
                    if (dies) begin
                        state_d = DEAD;
                        dead_d  = 1'b1;
                    end else begin
                        new_len   = eat ? length_q + LW'(1) : length_q;
                        length_d  = new_len;
                        body_d[0] = nh;
                        for (int i = 1; i < MAX_LEN; i++) begin
                            body_d[i] = (LW'(i) < new_len) ? body_q[i-1] : '0;
                        end
                        if (eat) begin
                            score_d      = score_q + LW'(1);
                            score_flag_d = 1'b1;
                            if (new_len == LW'(MAX_LEN)) begin
                                state_d = WIN;
                                win_d   = 1'b1;
                            end else begin
                                state_d = PLACE;
                            end
                        end
                    end
                end
            end
            PLACE: begin
                if (tick) hold_d = 1'b1;
                if (!rnd_hit && rnd != BARRIER) begin
                    apple_d = rnd;
                    state_d = PLAY;
                end
            end
            default: ;
        endcase

        // Filter against the direction that will be committed after this edge.
        if ((state_q == PLAY || state_q == PLACE) && btn_any && !is_reverse(req, dir_d)) begin
            pend_d = req;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments in every sequential block keep register updates order-independent.
            state_q      <= PLAY;
            dir_q        <= RIGHT;
            pend_q       <= RIGHT;
            hold_q       <= 1'b0;
            length_q     <= LW'(INIT_LEN);
            score_q      <= '0;
            apple_q      <= {GRID_BITS'(G - 3), GRID_BITS'(C)};
            score_flag_q <= 1'b0;
            dead_q       <= 1'b0;
            win_q        <= 1'b0;
            // NOTE: the body array is reset too, since it drives the display directly and must start defined.
            for (int i = 0; i < MAX_LEN; i++) begin
                body_q[i] <= (i < INIT_LEN) ? {GRID_BITS'(C - i), GRID_BITS'(C)} : '0;
            end
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            hold_q       <= hold_d;
            length_q     <= length_d;
            score_q      <= score_d;
            apple_q      <= apple_d;
            score_flag_q <= score_flag_d;
            dead_q       <= dead_d;
            win_q        <= win_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_q[i] <= body_d[i];
            end
        end
    end

    // Flatten the body registers; unused slices are held at zero.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            body_flat[i*CW +: CW] = body_q[i];
        end
    end

    assign snake      = body_flat;
    assign length     = length_q;
    assign apple      = apple_q;
    assign barrier    = BARRIER;
    assign score      = score_q;
    assign score_flag = score_flag_q;
    assign dead_flag  = dead_q;
    assign win_flag   = win_q;

endmodule

// File: tb/tb_snake_core.sv
// Self-checking bench for snake_core: three instances (default, wrapping,
// MAX_LEN=4) share one stimulus stream; step vectors go through a scoreboard.
module tb_snake_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [7:0] rnd = 8'h44;

    logic [127:0] snake_a, snake_w;
    logic [31:0]  snake_m;
    logic [4:0]   len_a, len_w, score_a, score_w;
    logic [2:0]   len_m, score_m;
    logic [7:0]   apple_a, apple_w, apple_m, barrier_a, barrier_w, barrier_m;
    logic         sflag_a, sflag_w, sflag_m;
    logic         dead_a, dead_w, dead_m;
    logic         win_a, win_w, win_m;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] btn;   // {up, down, left, right}
        logic [7:0] head;
        logic [4:0] len;
        logic [4:0] score;
        logic       sflag;
        logic       dead;
    } vec_t;

    vec_t sb[$];
    vec_t tbl_a[7];
    vec_t tbl_b[9];
    vec_t tbl_c[13];

    always #5 clk = ~clk;

    snake_core dut_a (
        .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .left(left), .right(right),
        .rnd(rnd), .snake(snake_a), .length(len_a), .apple(apple_a), .barrier(barrier_a),
        .score(score_a), .score_flag(sflag_a), .dead_flag(dead_a), .win_flag(win_a)
    );

    snake_core #(.WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .left(left), .right(right),
        .rnd(rnd), .snake(snake_w), .length(len_w), .apple(apple_w), .barrier(barrier_w),
        .score(score_w), .score_flag(sflag_w), .dead_flag(dead_w), .win_flag(win_w)
    );

    snake_core #(.MAX_LEN(4)) dut_m (
        .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .left(left), .right(right),
        .rnd(rnd), .snake(snake_m), .length(len_m), .apple(apple_m), .barrier(barrier_m),
        .score(score_m), .score_flag(sflag_m), .dead_flag(dead_m), .win_flag(win_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] btn, input logic [7:0] head, input int len,
                                input int score, input logic sflag, input logic dead);
        vec_t v;
        v.btn = btn; v.head = head; v.len = 5'(len); v.score = 5'(score);
        v.sflag = sflag; v.dead = dead;
        return v;
    endfunction

    // Hold buttons one cycle, pulse tick, then compare against the scoreboard entry.
    task automatic apply_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        {up, down, left, right} = v.btn;
        @(negedge clk);
        tick = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        tick = 1'b0;
        {up, down, left, right} = 4'b0000;
        e = sb.pop_front();
        check("step_head",  32'(snake_a[7:0]), 32'(e.head));
        check("step_head_w", 32'(snake_w[7:0]), 32'(e.head));
        check("step_len",   32'(len_a), 32'(e.len));
        check("step_score", 32'(score_a), 32'(e.score));
        check("step_sflag", 32'(sflag_a), 32'(e.sflag));
        check("step_dead",  32'(dead_a), 32'(e.dead));
    endtask

    task automatic check_reset();
        check("rst_head",     32'(snake_a[7:0]), 32'h88);
        check("rst_seg1",     32'(snake_a[15:8]), 32'h78);
        check("rst_seg2",     32'(snake_a[23:16]), 32'h68);
        check("rst_tail0",    32'(|snake_a[127:24]), 32'h0);
        check("rst_len",      32'(len_a), 32'd3);
        check("rst_score",    32'(score_a), 32'd0);
        check("rst_apple",    32'(apple_a), 32'hD8);
        check("rst_barrier",  32'(barrier_a), 32'h44);
        check("rst_flags",    32'({sflag_a, dead_a, win_a}), 32'h0);
        check("rst_w_body",   32'(snake_w[23:0]), 32'h687888);
        check("rst_w_tail0",  32'(|snake_w[127:24]), 32'h0);
        check("rst_w_misc",   32'({len_w, score_w, apple_w, barrier_w}), 32'({5'd3, 5'd0, 8'hD8, 8'h44}));
        check("rst_w_flags",  32'({sflag_w, dead_w, win_w}), 32'h0);
        check("rst_m_body",   snake_m, 32'h00687888);
        check("rst_m_misc",   32'({len_m, score_m, apple_m, barrier_m}), 32'({3'd3, 3'd0, 8'hD8, 8'h44}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick = 1'b0;
        {up, down, left, right} = 4'b0000;
        #2;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Main run: 3 plain steps, reverse ignored, turns, eat at D8.
        tbl_a[0] = mk(4'b0000, 8'h98, 3, 0, 1'b0, 1'b0);
        tbl_a[1] = mk(4'b0000, 8'hA8, 3, 0, 1'b0, 1'b0);
        tbl_a[2] = mk(4'b0000, 8'hB8, 3, 0, 1'b0, 1'b0);
        tbl_a[3] = mk(4'b0010, 8'hC8, 3, 0, 1'b0, 1'b0);
        tbl_a[4] = mk(4'b1000, 8'hC7, 3, 0, 1'b0, 1'b0);
        tbl_a[5] = mk(4'b0001, 8'hD7, 3, 0, 1'b0, 1'b0);
        tbl_a[6] = mk(4'b0100, 8'hD8, 4, 1, 1'b1, 1'b0);
        // Barrier route: up to row 4, then left into 44.
        tbl_b[0] = mk(4'b1000, 8'h87, 3, 0, 1'b0, 1'b0);
        tbl_b[1] = mk(4'b0000, 8'h86, 3, 0, 1'b0, 1'b0);
        tbl_b[2] = mk(4'b0000, 8'h85, 3, 0, 1'b0, 1'b0);
        tbl_b[3] = mk(4'b0000, 8'h84, 3, 0, 1'b0, 1'b0);
        tbl_b[4] = mk(4'b0010, 8'h74, 3, 0, 1'b0, 1'b0);
        tbl_b[5] = mk(4'b0000, 8'h64, 3, 0, 1'b0, 1'b0);
        tbl_b[6] = mk(4'b0000, 8'h54, 3, 0, 1'b0, 1'b0);
        tbl_b[7] = mk(4'b0000, 8'h54, 3, 0, 1'b0, 1'b1);
        tbl_b[8] = mk(4'b0000, 8'h54, 3, 0, 1'b0, 1'b1);
        // Eat at D8 to reach length 4, then chase the tail round a 2x2 loop.
        tbl_c[0]  = mk(4'b0001, 8'h98, 3, 0, 1'b0, 1'b0);
        tbl_c[1]  = mk(4'b0000, 8'hA8, 3, 0, 1'b0, 1'b0);
        tbl_c[2]  = mk(4'b0000, 8'hB8, 3, 0, 1'b0, 1'b0);
        tbl_c[3]  = mk(4'b0000, 8'hC8, 3, 0, 1'b0, 1'b0);
        tbl_c[4]  = mk(4'b0000, 8'hD8, 4, 1, 1'b1, 1'b0);
        tbl_c[5]  = mk(4'b0100, 8'hD9, 4, 1, 1'b0, 1'b0);
        tbl_c[6]  = mk(4'b0010, 8'hC9, 4, 1, 1'b0, 1'b0);
        tbl_c[7]  = mk(4'b1000, 8'hC8, 4, 1, 1'b0, 1'b0);
        tbl_c[8]  = mk(4'b0001, 8'hD8, 4, 1, 1'b0, 1'b0);
        tbl_c[9]  = mk(4'b0100, 8'hD9, 4, 1, 1'b0, 1'b0);
        tbl_c[10] = mk(4'b0010, 8'hC9, 4, 1, 1'b0, 1'b0);
        tbl_c[11] = mk(4'b1000, 8'hC8, 4, 1, 1'b0, 1'b0);
        tbl_c[12] = mk(4'b0001, 8'hD8, 4, 1, 1'b0, 1'b0);

        do_reset();
        rnd = 8'h44;
        for (int i = 0; i < 7; i++) apply_vec(tbl_a[i]);

        // MAX_LEN=4 instance won on that same eat.
        check("win_flag",   32'(win_m), 32'h1);
        check("win_score",  32'(score_m), 32'd1);
        check("win_len",    32'(len_m), 32'd4);
        check("win_apple",  32'(apple_m), 32'hD8);
        check("win_body",   snake_m, 32'hC8C7D7D8);
        check("win_sflag",  32'({sflag_m, dead_m}), 32'h2);

        // Placement: reject barrier, reject body cell, accept 22; tick during PLACE is held.
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("sflag_one_cycle", 32'(sflag_a), 32'h0);
        check("place_rej_bar",   32'(apple_a), 32'hD8);
        rnd = 8'hC7;
        @(negedge clk);
        check("place_rej_body",  32'(apple_a), 32'hD8);
        rnd = 8'h22;
        @(negedge clk);
        check("place_accept",    32'(apple_a), 32'h22);
        check("place_no_move",   32'(snake_a[7:0]), 32'hD8);
        @(negedge clk);
        check("held_step",       32'(snake_a[7:0]), 32'hD9);
        check("held_step_seg1",  32'(snake_a[15:8]), 32'hD8);

        // Edge exit: default dies, wrapping instance reappears at x=0.
        apply_vec(mk(4'b0001, 8'hE9, 4, 1, 1'b0, 1'b0));
        apply_vec(mk(4'b0000, 8'hF9, 4, 1, 1'b0, 1'b0));
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("edge_dead",       32'(dead_a), 32'h1);
        check("edge_frozen",     32'(snake_a[31:0]), 32'hD8D9E9F9);
        check("wrap_head",       32'(snake_w[7:0]), 32'h09);
        check("wrap_alive",      32'(dead_w), 32'h0);
        {up, left} = 2'b11;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        {up, left} = 2'b00;
        check("dead_frozen",     32'(snake_a[31:0]), 32'hD8D9E9F9);
        check("dead_len",        32'(len_a), 32'd4);
        check("dead_tail0",      32'(snake_a[39:32]), 32'h0);
        check("dead_sticky",     32'(dead_a), 32'h1);
        check("wrap_head2",      32'(snake_w[7:0]), 32'h19);
        check("win_frozen",      32'({win_m, snake_m[7:0]}), 32'h1D8);

        // Barrier collision.
        do_reset();
        for (int i = 0; i < 9; i++) apply_vec(tbl_b[i]);

        // Tail chase at length 4.
        do_reset();
        rnd = 8'h22;
        for (int i = 0; i < 13; i++) apply_vec(tbl_c[i]);
        check("chase_apple",     32'(apple_a), 32'h22);

        // Reset asserted while stuck in PLACE.
        do_reset();
        rnd = 8'h44;
        for (int i = 0; i < 5; i++) apply_vec(tbl_c[i]);
        @(negedge clk);
        @(negedge clk);
        check("stuck_place",     32'(apple_a), 32'hD8);
        #2;
        rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
        apply_vec(tbl_a[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
